mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache refill path (read-only) and the data-cache refill/write-back path (read/write).
- Sits below both caches. Each requester sees a busywait handshake identical to a private memory, so the pipeline stall logic (busywait into the pipeline registers) is unchanged.
- Fixed data-side priority with an instruction-side starvation guard.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_starve_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter and the cache/memory
// models that sit around it.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF   = 28;   // block address (byte address >> 4)
  localparam int LINE_W_DEF   = 128;  // one cache line
  localparam int STARVE_W     = 4;
  localparam logic [STARVE_W-1:0] STARVE_SAT = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_GRANT = 2'd1,
    D_GRANT = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts data-side completions that happened while an instruction request
// was waiting, and flags when that request must win the next decision.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic inc,
  input  logic clr,
  input  logic i_read,
  output logic starving
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt;

  // Saturating count; clear has priority so an I completion always restarts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                         cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && cnt != STARVE_SAT) cnt <= cnt + 1'b1;
  end

  assign starving = i_read && (cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache refill path and the
// D-cache refill/write-back path. Each side sees a private-memory busywait.
// Data wins by default; an instruction request that has watched
// STARVE_LIMIT data transactions go by wins the next decision.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int LINE_W       = LINE_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [LINE_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [LINE_W-1:0] D_WRITEDATA,
  output logic [LINE_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [LINE_W-1:0] MEM_WRITEDATA,
  input  logic [LINE_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  arb_state_e        state, state_nxt;
  logic              d_req, i_done, d_done, starving;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  assign d_req  = D_READ | D_WRITE;
  // Completion: a grant state with memory no longer busy.
  assign i_done = (state == I_GRANT) && !MEM_BUSYWAIT;
  assign d_done = (state == D_GRANT) && !MEM_BUSYWAIT;

  assign I_BUSYWAIT = I_READ && !i_done;
  assign D_BUSYWAIT = d_req  && !d_done;

  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .CLK      (CLK),
    .RESET    (RESET),
    .inc      (d_done && I_READ),
    .clr      (i_done || (state == IDLE && !I_READ)),
    .i_read   (I_READ),
    .starving (starving)
  );

  // State register; async reset drops the strobes at once since they decode state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant decision, memory-side mux and transaction sequencing.
  always_comb begin
    state_nxt     = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = addr_q;
    MEM_WRITEDATA = wdata_q;
    case (state)
      IDLE: begin
        if (d_req && !starving) state_nxt = D_GRANT;
        else if (I_READ)        state_nxt = I_GRANT;
      end
      I_GRANT: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = I_ADDRESS;
        if (!MEM_BUSYWAIT) state_nxt = RELEASE;
      end
      D_GRANT: begin
        // Read and write together is a write-back.
        MEM_WRITE     = D_WRITE;
        MEM_READ      = !D_WRITE;
        MEM_ADDRESS   = D_ADDRESS;
        MEM_WRITEDATA = D_WRITEDATA;
        if (!MEM_BUSYWAIT) state_nxt = RELEASE;
      end
      // One dead cycle so a request still high from the last grant is not re-granted.
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data hold their last driven value outside grants.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= MEM_ADDRESS;
      wdata_q <= MEM_WRITEDATA;
    end
  end

  // Capture read lines for the granted side only at its completion edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      I_READDATA <= '0;
      D_READDATA <= '0;
    end else begin
      if (i_done)             I_READDATA <= MEM_READDATA;
      if (d_done && !D_WRITE) D_READDATA <= MEM_READDATA;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a line-level
// memory image and transaction-order rules (data priority, starvation bound).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW    = ADDR_W_DEF;
  localparam int LW    = LINE_W_DEF;
  localparam int LIMIT = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_READ, D_READ, D_WRITE;
  logic [AW-1:0] I_ADDRESS, D_ADDRESS;
  logic [LW-1:0] I_READDATA, D_READDATA, D_WRITEDATA;
  logic          I_BUSYWAIT, D_BUSYWAIT;
  logic          MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [AW-1:0] MEM_ADDRESS;
  logic [LW-1:0] MEM_WRITEDATA, MEM_READDATA;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory image: I lines in bit27=0 region, D lines in bit27=1 region, 16 each.
  function automatic int midx(input logic [AW-1:0] a);
    return int'({a[AW-1], a[3:0]});
  endfunction

  function automatic logic [LW-1:0] init_line(input int i);
    if (i == 0) return {16{8'hA5}};
    return {4{32'hC0DE0000 + 32'(i) * 32'h01010101}};
  endfunction

  logic [LW-1:0] mem [32];
  logic [LW-1:0] ref_mem [32];
  int            mem_lat = 3;
  int            mcnt;
  logic          stb_m;

  assign stb_m        = MEM_READ | MEM_WRITE;
  assign MEM_BUSYWAIT = stb_m && (mcnt < mem_lat - 1);
  assign MEM_READDATA = (stb_m && !MEM_BUSYWAIT) ? mem[midx(MEM_ADDRESS)] : {4{32'hDEADBEEF}};

  // Memory model: mem_lat strobe cycles per transaction, write lands at completion.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcnt <= 0;
      for (int i = 0; i < 32; i++) mem[i] <= init_line(i);
    end else begin
      if (stb_m && MEM_BUSYWAIT) mcnt <= mcnt + 1;
      else                       mcnt <= 0;
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[midx(MEM_ADDRESS)] <= MEM_WRITEDATA;
    end
  end

  task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  int wcnt;  // D completions seen while the current I request waited

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = init_line(i);
    wcnt = 0;
  endtask

  task automatic do_reset();
    I_READ = 0; D_READ = 0; D_WRITE = 0;
    RESET = 1;
    tick(); tick();
    RESET = 0;
    ref_reset();
  endtask

  // Waits for the selected side's busywait to fall with its request held.
  task automatic wait_done(input bit dside, output int done_at);
    done_at = -1;
    for (int n = 0; n < 40 && done_at < 0; n++) begin
      @(negedge CLK);
      if (dside ? !D_BUSYWAIT : !I_BUSYWAIT) done_at = n;
      tick();
    end
    chkb(dside ? "d_done_in_time" : "i_done_in_time", done_at >= 0, 1'b1);
  endtask

  int first, done, dn, gstart, i_first, i_done, d_done, i_low_in_d, d_cnt;
  logic g_owner, g_wr, g_rd, dd, id;
  logic [LW-1:0] g_wd, wd, old;
  logic [AW-1:0] g_addr;
  // random-phase state
  logic stb, prev_stb, prev_i, prev_d, i_fin, d_fin;
  logic [LW-1:0] d_last;
  int i_age, d_age, r;

  initial begin
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
    I_READ = 0; D_READ = 0; D_WRITE = 0;
    RESET = 1;
    tick();
    // reset state
    chkb("rst_mem_read",  MEM_READ,  1'b0);
    chkb("rst_mem_write", MEM_WRITE, 1'b0);
    chki("rst_mem_addr",  int'(MEM_ADDRESS), 0);
    chkw("rst_mem_wdata", MEM_WRITEDATA, '0);
    chkw("rst_i_rdata",   I_READDATA, '0);
    chkw("rst_d_rdata",   D_READDATA, '0);
    tick();
    RESET = 0;
    ref_reset();

    // 1: lone I read, latency 5
    mem_lat = 5;
    I_READ = 1; I_ADDRESS = 28'h0000010;
    first = -1; done = -1;
    for (int n = 0; n < 20 && done < 0; n++) begin
      @(negedge CLK);
      if (MEM_READ && first < 0) first = n;
      if (!I_BUSYWAIT) done = n;
      tick();
    end
    I_READ = 0;
    chki("t1_grant_cycle", first, 1);
    chki("t1_done_cycle",  done, 5);
    chkw("t1_rdata", I_READDATA, {16{8'hA5}});
    @(negedge CLK);
    chkb("t1_release_idle", MEM_READ, 1'b0);
    tick();
    @(negedge CLK);
    chkb("t1_idle_quiet", MEM_READ, 1'b0);
    tick();

    // 2: I read and D write raised together; D first
    mem_lat = 3;
    wd = {$urandom, $urandom, $urandom, $urandom};
    I_READ = 1; I_ADDRESS = 28'h0000021;
    D_WRITE = 1; D_ADDRESS = 28'h8000003; D_WRITEDATA = wd;
    gstart = -1; i_first = -1; i_done = -1; d_done = -1; i_low_in_d = 0;
    for (int n = 0; n < 40 && i_done < 0; n++) begin
      @(negedge CLK);
      if (stb_m && gstart < 0) begin
        gstart = n; g_owner = MEM_ADDRESS[AW-1]; g_wr = MEM_WRITE; g_rd = MEM_READ; g_wd = MEM_WRITEDATA;
      end
      if (D_WRITE && !I_BUSYWAIT) i_low_in_d++;
      if (MEM_READ && !MEM_ADDRESS[AW-1] && i_first < 0) i_first = n;
      dd = D_WRITE && !D_BUSYWAIT;
      if (dd) d_done = n;
      if (I_READ && !I_BUSYWAIT) i_done = n;
      tick();
      if (dd) D_WRITE = 0;
    end
    I_READ = 0;
    ref_mem[midx(28'h8000003)] = wd;
    chkb("t2_d_first",   g_owner, 1'b1);
    chkb("t2_mem_write", g_wr, 1'b1);
    chkb("t2_mem_read",  g_rd, 1'b0);
    chkw("t2_wdata",     g_wd, wd);
    chki("t2_i_stalled_during_d", i_low_in_d, 0);
    chki("t2_i_grant_after_release", i_first, d_done + 3);
    chkw("t2_i_rdata", I_READDATA, ref_mem[midx(28'h0000021)]);
    tick();

    // 3: starvation guard, D issues back-to-back reads while I waits
    mem_lat = 2;
    I_READ = 1; I_ADDRESS = 28'h0000022;
    D_READ = 1; D_ADDRESS = 28'h8000003;
    d_cnt = 0; i_done = -1;
    for (int n = 0; n < 60 && i_done < 0; n++) begin
      @(negedge CLK);
      dd = D_READ && !D_BUSYWAIT;
      id = I_READ && !I_BUSYWAIT;
      if (id) i_done = n;
      tick();
      if (dd) begin
        d_cnt++;
        chkw($sformatf("t3_d_rdata%0d", d_cnt), D_READDATA, ref_mem[midx(D_ADDRESS)]);
        D_ADDRESS = 28'h8000000 | 28'(d_cnt + 3);
      end
    end
    I_READ = 0;
    chki("t3_d_before_i", d_cnt, LIMIT);
    chkw("t3_i_rdata", I_READDATA, ref_mem[midx(28'h0000022)]);
    wait_done(1'b1, dn);
    chkw("t3_d_after_i", D_READDATA, ref_mem[midx(D_ADDRESS)]);
    D_READ = 0;
    tick();

    // 4: D read and write together behave as a write
    mem_lat = 4;
    old = D_READDATA;
    wd = {$urandom, $urandom, $urandom, $urandom};
    D_READ = 1; D_WRITE = 1; D_ADDRESS = 28'h8000007; D_WRITEDATA = wd;
    gstart = -1; done = -1;
    for (int n = 0; n < 20 && done < 0; n++) begin
      @(negedge CLK);
      if (stb_m && gstart < 0) begin gstart = n; g_wr = MEM_WRITE; g_rd = MEM_READ; end
      if (!D_BUSYWAIT) done = n;
      tick();
    end
    D_READ = 0; D_WRITE = 0;
    ref_mem[midx(28'h8000007)] = wd;
    chkb("t4_write", g_wr, 1'b1);
    chkb("t4_no_read", g_rd, 1'b0);
    chkw("t4_rdata_unchanged", D_READDATA, old);
    tick();
    D_READ = 1; D_ADDRESS = 28'h8000007;
    wait_done(1'b1, dn);
    D_READ = 0;
    chkw("t4_readback", D_READDATA, wd);
    tick();

    // 5: reset in grant cycle 3 of a 6-cycle D read
    mem_lat = 6;
    D_READ = 1; D_ADDRESS = 28'h8000004;
    tick(); tick(); tick();
    @(negedge CLK);
    chkb("t5_in_grant", MEM_READ, 1'b1);
    #1 RESET = 1;
    #1;
    chkb("t5_rst_read",  MEM_READ,  1'b0);
    chkb("t5_rst_write", MEM_WRITE, 1'b0);
    chkw("t5_rst_i_rdata", I_READDATA, '0);
    chkw("t5_rst_d_rdata", D_READDATA, '0);
    @(posedge CLK); #1;
    RESET = 0;
    ref_reset();
    @(negedge CLK);
    chkb("t5_idle_after_rst", MEM_READ, 1'b0);
    tick();
    @(negedge CLK);
    chkb("t5_regrant", MEM_READ, 1'b1);
    chki("t5_regrant_addr", int'(MEM_ADDRESS), int'(28'h8000004));
    tick();
    wait_done(1'b1, dn);
    D_READ = 0;
    chkw("t5_rdata", D_READDATA, ref_mem[midx(28'h8000004)]);
    tick();

    // 6: back-to-back I reads, new request seen during RELEASE
    mem_lat = 3;
    I_READ = 1; I_ADDRESS = 28'h0000025;
    wait_done(1'b0, dn);
    chkw("t6_first_rdata", I_READDATA, ref_mem[midx(28'h0000025)]);
    I_ADDRESS = 28'h0000026;
    @(negedge CLK);
    chkb("t6_release_bw", I_BUSYWAIT, 1'b1);
    chkb("t6_release_rd", MEM_READ, 1'b0);
    tick();
    @(negedge CLK);
    chkb("t6_idle_bw", I_BUSYWAIT, 1'b1);
    chkb("t6_idle_rd", MEM_READ, 1'b0);
    tick();
    @(negedge CLK);
    chkb("t6_grant_rd", MEM_READ, 1'b1);
    chki("t6_grant_addr", int'(MEM_ADDRESS), int'(28'h0000026));
    tick();
    wait_done(1'b0, dn);
    I_READ = 0;
    chkw("t6_second_rdata", I_READDATA, ref_mem[midx(28'h0000026)]);

    // random traffic against the memory image and ordering rules
    do_reset();
    d_last = '0; prev_stb = 0; prev_i = 0; prev_d = 0; g_owner = 0; i_age = 0; d_age = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      stb = MEM_READ | MEM_WRITE;
      if (stb && !prev_stb) begin
        g_owner = MEM_ADDRESS[AW-1];
        if (!g_owner) begin
          chkb("r_i_grant_req", I_READ, 1'b1);
          chkb("r_i_grant_rd", MEM_READ && !MEM_WRITE, 1'b1);
          if (prev_d) chkb("r_i_over_d_starved", wcnt >= LIMIT, 1'b1);
        end else begin
          chkb("r_d_grant_req", D_READ | D_WRITE, 1'b1);
          chkb("r_d_grant_wr", MEM_WRITE, D_WRITE);
          chkb("r_d_grant_rd", MEM_READ, !D_WRITE);
          if (prev_i) chkb("r_d_over_i_not_starved", wcnt < LIMIT, 1'b1);
        end
      end
      if (stb) begin
        chki("r_addr", int'(MEM_ADDRESS), int'(g_owner ? D_ADDRESS : I_ADDRESS));
        if (g_owner && D_WRITE) chkw("r_wdata", MEM_WRITEDATA, D_WRITEDATA);
      end
      i_fin = I_READ && !I_BUSYWAIT;
      d_fin = (D_READ | D_WRITE) && !D_BUSYWAIT;
      chkb("r_i_bw", I_BUSYWAIT, I_READ && !(stb && !g_owner && !MEM_BUSYWAIT));
      chkb("r_d_bw", D_BUSYWAIT, (D_READ | D_WRITE) && !(stb && g_owner && !MEM_BUSYWAIT));
      prev_stb = stb; prev_i = I_READ; prev_d = D_READ | D_WRITE;
      if (d_fin && I_READ) wcnt++;
      if (i_fin) wcnt = 0;
      tick();
      if (i_fin) begin
        chkw("r_i_rdata", I_READDATA, ref_mem[midx(I_ADDRESS)]);
        I_READ = 0; i_age = 0;
      end
      if (d_fin) begin
        if (D_WRITE) begin
          ref_mem[midx(D_ADDRESS)] = D_WRITEDATA;
          chkw("r_d_rdata_hold", D_READDATA, d_last);
        end else begin
          d_last = ref_mem[midx(D_ADDRESS)];
          chkw("r_d_rdata", D_READDATA, d_last);
        end
        D_READ = 0; D_WRITE = 0; d_age = 0;
      end
      if (I_READ) begin i_age++; chkb("r_i_wait_bound", i_age < 40, 1'b1); end
      if (D_READ | D_WRITE) begin d_age++; chkb("r_d_wait_bound", d_age < 40, 1'b1); end
      if (!stb_m) mem_lat = $urandom_range(2, 6);
      if (!I_READ && $urandom_range(0, 2) == 0) begin
        I_READ = 1;
        I_ADDRESS = {1'b0, 23'($urandom), 4'($urandom)};
      end
      if (!(D_READ | D_WRITE) && $urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 3);
        D_ADDRESS   = {1'b1, 23'($urandom), 4'($urandom)};
        D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        D_WRITE = (r <= 1);
        D_READ  = (r >= 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
